// File: rtl/rom_read_responder.sv
// ----------------------------------------------------------------------------
// rom_read_responder
//
// Memory-side responder for the ROM read protocol. A DEPTH x 32-bit table
// serves ce/addr requests. After a fixed LATENCY, it returns the word with a
// single-cycle data_valid pulse. A load port fills the table at runtime, and
// rd_count tracks completed responses.
//
// Handshake (ce / data_valid):
//   The requester raises ce with a stable addr and holds ce high until it
//   sees data_valid. The responder captures mem[addr] on the first rising
//   edge where ce is high in IDLE. It pulses data_valid for exactly one cycle,
//   in the cycle after edge capture+LATENCY. Any ce still high after the
//   response belongs to the request that was just served and is never served
//   again. A new request is accepted only after ce has been seen low. If ce
//   drops while the responder waits for the latency, the request is abandoned
//   and no pulse follows.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   synchronous, active-low reset
//   ce         in   request enable
//   addr       in   [7:0]  word address, stable while ce is high
//   rom_data   out  [31:0] response word, valid while data_valid=1
//   data_valid out  single-cycle response strobe
//   busy       out  high from the cycle after capture through the response cycle
//   ld_en      in   write ld_data to mem[ld_addr] at this edge
//   ld_addr    in   [7:0]  load address
//   ld_data    in   [31:0] load data
//   rd_count   out  [15:0] completed responses, saturating at 16'hFFFF
//   state_dbg  out  [1:0]  FSM state (0 IDLE, 1 WAIT_LAT, 2 RESP, 3 HOLD)
// ----------------------------------------------------------------------------
module rom_read_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2    // legal range 1..15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic [7:0]  addr,
   output logic [31:0] rom_data,
   output logic        data_valid,
   output logic        busy,
   input  logic        ld_en,
   input  logic [7:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic [15:0] rd_count,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_LAT = 2'd1,
      RESP     = 2'd2,
      HOLD     = 2'd3
   } state_t;

   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   state_t      state;
   logic [3:0]  lat_cnt;
   logic [31:0] data_reg;
   logic [31:0] mem [DEPTH];

   assign state_dbg = state;

   // Table storage. It is not reset, so loaded contents survive rst_n.
   // The capture in the FSM reads mem with a non-blocking sample at the same
   // edge. A same-cycle load to the captured address therefore returns the
   // old word.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         lat_cnt    <= 4'd0;
         data_reg   <= 32'd0;
         rom_data   <= 32'd0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         rd_count   <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               data_valid <= 1'b0;
               if (ce) begin
                  data_reg <= mem[addr];
                  lat_cnt  <= LAT_LOAD;
                  busy     <= 1'b1;
                  state    <= (LATENCY == 1) ? RESP : WAIT_LAT;
               end
            end

            WAIT_LAT: begin
               if (!ce) begin
                  // Requester gave up: drop the pending word silently.
                  state   <= IDLE;
                  busy    <= 1'b0;
                  lat_cnt <= 4'd0;
               end else if (lat_cnt == 4'd1) begin
                  state   <= RESP;
                  lat_cnt <= 4'd0;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end

            RESP: begin
               // The registered outputs land one cycle later. That extra
               // cycle is why the counter is loaded with LATENCY-1.
               data_valid <= 1'b1;
               rom_data   <= data_reg;
               busy       <= 1'b1;
               if (rd_count != 16'hFFFF) begin
                  rd_count <= rd_count + 16'd1;
               end
               state <= HOLD;
            end

            HOLD: begin
               data_valid <= 1'b0;
               busy       <= 1'b0;
               if (!ce) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_read_responder.sv
// ----------------------------------------------------------------------------
// Directed bench for rom_read_responder.
// u_dut uses LATENCY=2. u_dut3 uses LATENCY=3 and covers the abort case and
// the longer latency. Inputs change just after the falling edge. Outputs are
// checked on the falling edge, which reflects the preceding rising edge.
// ----------------------------------------------------------------------------
module tb_rom_read_responder;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic        ce3;
   logic [7:0]  addr;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;

   logic [31:0] rom_data,  rom_data3;
   logic        dv,        dv3;
   logic        busy,      busy3;
   logic [15:0] rd_count,  rd_count3;
   logic [1:0]  st,        st3;

   int n_checks;
   int n_errors;
   int pulses;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   rom_read_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .addr(addr),
      .rom_data(rom_data), .data_valid(dv), .busy(busy),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_count(rd_count), .state_dbg(st)
   );

   rom_read_responder #(.DEPTH(256), .LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ce(ce3), .addr(addr),
      .rom_data(rom_data3), .data_valid(dv3), .busy(busy3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_count(rd_count3), .state_dbg(st3)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one full cycle and land on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld_en   = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      ce       = 1'b0;
      ce3      = 1'b0;
      addr     = 8'd0;
      ld_en    = 1'b0;
      ld_addr  = 8'd0;
      ld_data  = 32'd0;

      // ---------------- reset ----------------
      step(); step(); step();
      check("rst_dv",       32'(dv),       32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_rom_data", rom_data,      32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_state",    32'(st),       32'(S_IDLE));
      rst_n = 1'b1;
      step();

      load(8'h05, 32'hDEADBEEF);
      load(8'h01, 32'h11111111);
      load(8'h02, 32'h22222222);
      load(8'h10, 32'h12345678);

      // ---------------- basic read, LATENCY=2 ----------------
      ce = 1'b1; addr = 8'h05;
      step();  // capture edge N
      check("t1_busy_n",    32'(busy), 32'd1);
      check("t1_dv_n",      32'(dv),   32'd0);
      check("t1_state_n",   32'(st),   32'(S_WAIT));
      step();  // edge N+1
      check("t1_dv_n1",     32'(dv),   32'd0);
      check("t1_state_n1",  32'(st),   32'(S_RESP));
      step();  // edge N+2: response cycle
      check("t1_dv",        32'(dv),       32'd1);
      check("t1_data",      rom_data,      32'hDEADBEEF);
      check("t1_rd_count",  32'(rd_count), 32'd1);
      check("t1_busy_resp", 32'(busy),     32'd1);
      ce = 1'b0;
      step();
      check("t1_dv_after",   32'(dv),   32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);
      check("t1_state_idle", 32'(st),   32'(S_IDLE));
      check("t1_data_hold",  rom_data,  32'hDEADBEEF);

      // ---------------- back-to-back ----------------
      ce = 1'b1; addr = 8'h01;
      step();
      check("b2b1_dv0", 32'(dv), 32'd0);
      step();
      check("b2b1_dv1", 32'(dv), 32'd0);
      step();
      check("b2b1_dv",    32'(dv),       32'd1);
      check("b2b1_data",  rom_data,      32'h11111111);
      check("b2b1_count", 32'(rd_count), 32'd2);
      ce = 1'b0;
      step();
      check("b2b_gap0", 32'(dv), 32'd0);
      step();
      check("b2b_gap1", 32'(dv), 32'd0);
      ce = 1'b1; addr = 8'h02;
      step();
      check("b2b2_dv0", 32'(dv), 32'd0);
      step();
      check("b2b2_dv1", 32'(dv), 32'd0);
      step();
      check("b2b2_dv",    32'(dv),       32'd1);
      check("b2b2_data",  rom_data,      32'h22222222);
      check("b2b2_count", 32'(rd_count), 32'd3);
      ce = 1'b0;
      step();
      check("b2b_nodup0", 32'(dv), 32'd0);
      step();
      check("b2b_nodup1",  32'(dv),       32'd0);
      check("b2b_count_f", 32'(rd_count), 32'd3);

      // ---------------- load/capture collision ----------------
      ce = 1'b1; addr = 8'h10;
      ld_en = 1'b1; ld_addr = 8'h10; ld_data = 32'hAAAA0000;
      step();  // capture and write at the same edge
      ld_en = 1'b0;
      step();
      step();
      check("col_dv",    32'(dv),       32'd1);
      check("col_data",  rom_data,      32'h12345678);
      check("col_count", 32'(rd_count), 32'd4);
      ce = 1'b0;
      step();
      ce = 1'b1; addr = 8'h10;
      step();  // capture new word
      load(8'h10, 32'h55555555);  // load while the response is pending
      step();
      check("col2_dv",    32'(dv),       32'd1);
      check("col2_data",  rom_data,      32'hAAAA0000);
      check("col2_count", 32'(rd_count), 32'd5);
      ce = 1'b0;
      step();

      // ---------------- sticky ce ----------------
      ce = 1'b1; addr = 8'h01;
      step(); step(); step();
      check("sticky_dv",   32'(dv),  32'd1);
      check("sticky_data", rom_data, 32'h11111111);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (dv === 1'b1) pulses++;
      end
      check("sticky_pulses", 32'(pulses),   32'd0);
      check("sticky_hold",   32'(st),       32'(S_HOLD));
      check("sticky_busy",   32'(busy),     32'd0);
      check("sticky_count",  32'(rd_count), 32'd6);
      ce = 1'b0;
      step();
      check("sticky_idle", 32'(st), 32'(S_IDLE));

      // ---------------- LATENCY=3: abort, then full read ----------------
      ce3 = 1'b1; addr = 8'h05;
      step();
      check("abort_wait", 32'(st3), 32'(S_WAIT));
      ce3 = 1'b0;
      step();
      check("abort_idle", 32'(st3), 32'(S_IDLE));
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (dv3 === 1'b1) pulses++;
      end
      check("abort_pulses", 32'(pulses),    32'd0);
      check("abort_count",  32'(rd_count3), 32'd0);
      check("abort_busy",   32'(busy3),     32'd0);

      ce3 = 1'b1; addr = 8'h05;
      step();
      check("l3_dv_n", 32'(dv3), 32'd0);
      step();
      check("l3_dv_n1", 32'(dv3), 32'd0);
      step();
      check("l3_dv_n2",  32'(dv3), 32'd0);
      check("l3_state",  32'(st3), 32'(S_RESP));
      step();
      check("l3_dv",    32'(dv3),       32'd1);
      check("l3_data",  rom_data3,      32'hDEADBEEF);
      check("l3_count", 32'(rd_count3), 32'd1);
      ce3 = 1'b0;
      step();
      check("l3_dv_after", 32'(dv3), 32'd0);

      // ---------------- reset mid-request ----------------
      ce = 1'b1; addr = 8'h01;
      step();
      check("mrst_wait", 32'(st), 32'(S_WAIT));
      rst_n = 1'b0;
      ce    = 1'b0;
      step();
      rst_n = 1'b1;
      check("mrst_dv",       32'(dv),       32'd0);
      check("mrst_rom_data", rom_data,      32'd0);
      check("mrst_count",    32'(rd_count), 32'd0);
      check("mrst_state",    32'(st),       32'(S_IDLE));
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (dv === 1'b1) pulses++;
      end
      check("mrst_pulses", 32'(pulses), 32'd0);
      ce = 1'b1; addr = 8'h05;
      step(); step(); step();
      check("mrst_read_dv",    32'(dv),       32'd1);
      check("mrst_read_data",  rom_data,      32'hDEADBEEF);
      check("mrst_read_count", 32'(rd_count), 32'd1);
      ce = 1'b0;
      step();
      check("mrst_read_done", 32'(dv), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rom_read_responder.md
Name: rom_read_responder

Overview:
- Memory-side responder for the ROM read protocol driven by the FIFO-to-ROM requester: 256 x 32-bit storage serving ce/addr requests.
- Returns one data word with a single-cycle data_valid pulse after a fixed, parameterised latency.
- Provides a load port so the table can be filled at runtime.
- Replaces a bare BRAM behind the requester, with a defined handshake and a served-read counter.

Parameters:
- DEPTH, 256, number of 32-bit words; addressed by the 8-bit addr.
- LATENCY, 2, cycles from request capture to the data_valid pulse; legal range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- ce  input  1  request enable; held high by requester while waiting, dropped after data_valid
- addr  input  8  word address, stable while ce high
- rom_data  output  32  read data, valid when data_valid=1
- data_valid  output  1  single-cycle response strobe
- busy  output  1  high from capture until the response cycle, inclusive
- ld_en  input  1  load strobe: write ld_data to ld_addr this cycle
- ld_addr  input  8  load address
- ld_data  input  32  load data
- rd_count  output  16  number of completed responses, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; rom_data=0, data_valid=0, busy=0, rd_count=0; latency counter=0.
  - Memory contents are not reset.
  - Reset mid-operation abandons the pending response; no data_valid follows.
- States: IDLE, WAIT_LAT, RESP, HOLD.
- IDLE:
  - If ce=1, capture mem[addr] into the internal data register, load counter with LATENCY-1.
  - If LATENCY=1, go to RESP; otherwise go to WAIT_LAT. busy=1 from the next cycle.
- WAIT_LAT:
  - Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - If ce=0 in any WAIT_LAT cycle, the request is aborted: go to IDLE, no data_valid, rd_count unchanged.
- RESP:
  - data_valid=1 and rom_data=captured word, both registered outputs for exactly one cycle; busy=1.
  - rd_count increments by 1 (saturating). Next state is HOLD.
- HOLD:
  - data_valid=0, busy=0; wait for ce=0, then go to IDLE.
  - A ce still high after RESP belongs to the served request and is never re-served.
  - With the standard requester, ce is already 0 in HOLD, so HOLD lasts one cycle.
  - Back-to-back requests are therefore separated by at least one IDLE sample.
- Latency: if ce is sampled high in IDLE at edge N, data_valid is high in the cycle after edge N+LATENCY.
- rom_data holds its last value outside RESP. It updates only on entry to RESP and never returns to 0 except on reset.
- Load port:
  - ld_en=1 writes mem[ld_addr]=ld_data at the edge, in any state including during a pending request.
  - Same-cycle load and capture to the same address: capture returns the OLD word (read-before-write).
  - A load after capture does not alter the pending response.
- Address is 8 bits wide; DEPTH must be 256. No out-of-range case exists.

Test Plan:
- Load mem[0x05]=32'hDEADBEEF. Drive ce=1, addr=0x05 at edge 10 and hold until data_valid -> data_valid high for exactly one cycle after edge 12, rom_data=32'hDEADBEEF, rd_count=1, busy low one cycle later.
- Back-to-back: ce high addr=0x01, drop ce the cycle after data_valid, re-raise after 2 cycles with addr=0x02 (mem=11111111 / 22222222) -> two separate pulses with the correct data, rd_count=2, no duplicate pulse.
- Abort: raise ce, drop it after 1 cycle (LATENCY=3 build) -> no data_valid, rd_count stays 0, state returns to IDLE.
- Collision: ld_en with ld_addr=0x10, ld_data=0xAAAA0000 in the capture cycle of a read to 0x10 that previously held 0x12345678 -> response 0x12345678; a following read returns 0xAAAA0000.
- Reset mid-request: assert rst_n=0 during WAIT_LAT -> data_valid never pulses, rom_data=0, rd_count=0. Memory keeps loaded values, so the next read of 0x05 returns 32'hDEADBEEF.
- Sticky ce: hold ce=1 for 10 cycles after data_valid -> exactly one pulse; the responder stays in HOLD until ce=0.
